pipeline_ctrl: RTL and testbench

Central stall/flush/enable controller for the 5-stage MIPS pipeline. It consumes the hazard-relevant fields read out of the IF/ID and ID/EX pipeline registers and drives the `i_enable` / `i_flush` inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It sequences run mode, debug single-step mode and the end-of-program drain triggered by the halt flag (`jmp_stop`) reaching EX.

---
 rtl/pipeline_ctrl_pkg.sv | 20 ++
 rtl/pipeline_ctrl_load_use.sv | 15 +
 rtl/pipeline_ctrl.sv | 99 +++++++++
 tb/tb_pipeline_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush/enable controller:
// state encodings, default drain length and level helpers.
package pipeline_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RUN       = 3'd1,
    S_STEP_WAIT = 3'd2,
    S_STEP_ADV  = 3'd3,
    S_DRAIN     = 3'd4,
    S_HALTED    = 3'd5
  } state_t;

  localparam int   DEFAULT_DRAIN_CYCLES = 3;

  localparam logic LOW   = 1'b0;
  localparam logic HIGH  = 1'b1;
  localparam logic CLEAR = 1'b0;

endpackage

// File: rtl/pipeline_ctrl_load_use.sv
// Load-use hazard compare: a load in EX whose destination feeds the instruction in ID.
// Purely combinational so the forwarding unit can share it.
module load_use_detector (
  input  logic       i_ex_mem_read,
  input  logic [4:0] i_ex_rt,
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  output logic       o_stall
);

  // $zero is never a real dependency.
  assign o_stall = i_ex_mem_read && (i_ex_rt != 5'd0) &&
                   ((i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush/enable sequencer for the 5-stage pipeline: run, single-step,
// and halt drain. Outputs decode combinationally from state and hazard inputs.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES,
  parameter int CNT_SIZE     = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic       i_mode,
  input  logic       i_step,
  input  logic       i_clear,
  input  logic       i_ex_mem_read,
  input  logic [4:0] i_ex_rt,
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_id_branch_taken,
  input  logic       i_ex_halt,
  output logic       o_pc_enable,
  output logic       o_if_id_enable,
  output logic       o_if_id_flush,
  output logic       o_id_ex_enable,
  output logic       o_id_ex_flush,
  output logic       o_ex_mem_enable,
  output logic       o_mem_wb_enable,
  output logic       o_halted,
  output logic       o_busy
);

  localparam logic [CNT_SIZE-1:0] DRAIN_LOAD = CNT_SIZE'(DRAIN_CYCLES - 1);
  // With a single drain cycle the halt cycle itself is the only EX/MEM advance.
  localparam state_t HALT_NEXT = (DRAIN_CYCLES > 1) ? S_DRAIN : S_HALTED;

  state_t              state;
  logic [CNT_SIZE-1:0] cnt;
  logic                lu_hit;
  logic                advance, halt_fire, stall, branch_flush, cnt_last;

  load_use_detector u_load_use (
    .i_ex_mem_read (i_ex_mem_read),
    .i_ex_rt       (i_ex_rt),
    .i_id_rs       (i_id_rs),
    .i_id_rt       (i_id_rt),
    .o_stall       (lu_hit)
  );

  assign advance      = (state == S_RUN) || (state == S_STEP_ADV);
  assign halt_fire    = advance && i_ex_halt;
  assign stall        = advance && !halt_fire && lu_hit;
  assign branch_flush = advance && !halt_fire && !lu_hit && i_id_branch_taken;
  assign cnt_last     = (cnt == CNT_SIZE'(1)) || (cnt == '0);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE:      if (i_start) state <= i_mode ? S_STEP_WAIT : S_RUN;
        S_RUN: begin
          if (i_ex_halt) begin
            cnt   <= DRAIN_LOAD;
            state <= HALT_NEXT;
          end
        end
        S_STEP_WAIT: if (i_step) state <= S_STEP_ADV;
        S_STEP_ADV: begin
          if (i_ex_halt) begin
            cnt   <= DRAIN_LOAD;
            state <= HALT_NEXT;
          end else begin
            state <= S_STEP_WAIT;
          end
        end
        // Counter reaching zero ends the drain; i_step has no effect here.
        S_DRAIN: begin
          cnt <= cnt - CNT_SIZE'(1);
          if (cnt_last) state <= S_HALTED;
        end
        S_HALTED:    if (i_clear) state <= S_IDLE;
        default:     state <= S_IDLE;
      endcase
    end
  end

  assign o_pc_enable     = advance && !halt_fire && !stall;
  assign o_if_id_enable  = advance && !halt_fire && !stall;
  assign o_if_id_flush   = branch_flush ? HIGH : LOW;
  assign o_id_ex_enable  = advance && !halt_fire;
  assign o_id_ex_flush   = stall ? HIGH : CLEAR;
  assign o_ex_mem_enable = advance || (state == S_DRAIN);
  assign o_mem_wb_enable = advance || (state == S_DRAIN);
  assign o_halted        = (state == S_HALTED);
  assign o_busy          = (state == S_RUN) || (state == S_STEP_WAIT) ||
                           (state == S_STEP_ADV) || (state == S_DRAIN);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: stimulus pushes hand-computed output
// vectors, a negedge monitor pops and compares them against the DUT.
module tb_pipeline_ctrl;

  // {pc, if_id_en, if_id_fl, id_ex_en, id_ex_fl, ex_mem, mem_wb, halted, busy}
  localparam logic [8:0] E_IDLE  = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] E_RUN   = 9'b1_1_0_1_0_1_1_0_1;
  localparam logic [8:0] E_STALL = 9'b0_0_0_1_1_1_1_0_1;
  localparam logic [8:0] E_BR    = 9'b1_1_1_1_0_1_1_0_1;
  localparam logic [8:0] E_DRN   = 9'b0_0_0_0_0_1_1_0_1;
  localparam logic [8:0] E_HLT   = 9'b0_0_0_0_0_0_0_1_0;
  localparam logic [8:0] E_WAIT  = 9'b0_0_0_0_0_0_0_0_1;

  typedef struct {
    logic [8:0] exp;
    string      name;
  } sb_item_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 0, mode = 0, step = 0, clr = 0;
  logic       mrd = 0, br = 0, hlt = 0;
  logic [4:0] ex_rt = 0, id_rs = 0, id_rt = 0;
  logic       pc_en, ifid_en, ifid_fl, idex_en, idex_fl, exm_en, mwb_en, halted, busy;

  sb_item_t   sb_q[$];
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.DRAIN_CYCLES(3), .CNT_SIZE(2)) dut (
    .i_clk             (clk),
    .i_reset           (rst),
    .i_start           (start),
    .i_mode            (mode),
    .i_step            (step),
    .i_clear           (clr),
    .i_ex_mem_read     (mrd),
    .i_ex_rt           (ex_rt),
    .i_id_rs           (id_rs),
    .i_id_rt           (id_rt),
    .i_id_branch_taken (br),
    .i_ex_halt         (hlt),
    .o_pc_enable       (pc_en),
    .o_if_id_enable    (ifid_en),
    .o_if_id_flush     (ifid_fl),
    .o_id_ex_enable    (idex_en),
    .o_id_ex_flush     (idex_fl),
    .o_ex_mem_enable   (exm_en),
    .o_mem_wb_enable   (mwb_en),
    .o_halted          (halted),
    .o_busy            (busy)
  );

  // Monitor: the DUT presents a fresh output vector every cycle.
  always @(negedge clk) begin
    sb_item_t   it;
    logic [8:0] got;
    if (sb_q.size() > 0) begin
      it  = sb_q.pop_front();
      got = {pc_en, ifid_en, ifid_fl, idex_en, idex_fl, exm_en, mwb_en, halted, busy};
      total++;
      if (got !== it.exp) begin
        bad++;
        $display("FAIL %s: got %b want %b", it.name, got, it.exp);
      end
    end
  end

  // One cycle of stimulus: drive just after the edge, queue the expectation.
  task automatic cyc(input logic r, input logic s, input logic m, input logic st,
                     input logic c, input logic rd, input logic [4:0] xrt,
                     input logic [4:0] rs, input logic [4:0] rt, input logic b,
                     input logic h, input logic [8:0] exp, input string name);
    sb_item_t it;
    @(posedge clk);
    #1;
    rst = r; start = s; mode = m; step = st; clr = c;
    mrd = rd; ex_rt = xrt; id_rs = rs; id_rt = rt; br = b; hlt = h;
    it.exp  = exp;
    it.name = name;
    sb_q.push_back(it);
  endtask

  task automatic idle_cyc(input logic [8:0] exp, input string name);
    cyc(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, exp, name);
  endtask

  initial begin
    // Reset and start in run mode
    cyc(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, E_IDLE, "reset");
    cyc(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, E_IDLE, "start_idle");
    idle_cyc(E_RUN, "run");
    // Load-use stall for one cycle, then $zero and no-read cases
    cyc(0, 0, 0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0, 0, E_STALL, "lu_rs");
    idle_cyc(E_RUN, "lu_release");
    cyc(0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0, E_RUN, "lu_zero");
    cyc(0, 0, 0, 0, 0, 1, 5'd6, 5'd5, 5'd9, 0, 0, E_RUN, "lu_nomatch");
    cyc(0, 0, 0, 0, 0, 0, 5'd5, 5'd5, 5'd0, 0, 0, E_RUN, "lu_noread");
    // Stall beats branch; branch alone flushes IF/ID
    cyc(0, 0, 0, 0, 0, 1, 5'd7, 5'd0, 5'd7, 1, 0, E_STALL, "lu_rt_br");
    cyc(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 0, E_BR, "branch");
    idle_cyc(E_RUN, "branch_release");
    cyc(0, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, E_RUN, "start_in_run");
    idle_cyc(E_RUN, "still_run");
    // Halt with simultaneous stall and branch: halt response only
    cyc(0, 0, 0, 0, 0, 1, 5'd3, 5'd3, 5'd0, 1, 1, E_DRN, "halt_k");
    cyc(0, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, E_DRN, "drain_k1");
    idle_cyc(E_DRN, "drain_k2");
    idle_cyc(E_HLT, "halted_k3");
    cyc(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, E_HLT, "start_in_halted");
    cyc(0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, E_HLT, "clear");
    idle_cyc(E_IDLE, "after_clear");
    // Reset mid-run: outputs drop within the same cycle
    cyc(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, E_IDLE, "start2");
    idle_cyc(E_RUN, "run2");
    cyc(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, E_IDLE, "reset_mid_run");
    idle_cyc(E_IDLE, "post_reset");
    // Step mode: three pulses spaced four cycles apart
    cyc(0, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, E_IDLE, "start_step");
    for (int p = 0; p < 3; p++) begin
      cyc(0, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, E_WAIT, "step_pulse");
      idle_cyc(E_RUN, "step_adv");
      idle_cyc(E_WAIT, "step_wait1");
      idle_cyc(E_WAIT, "step_wait2");
    end
    // Step held high for six cycles: alternate wait/advance
    for (int p = 0; p < 3; p++) begin
      cyc(0, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, E_WAIT, "hold_wait");
      cyc(0, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, E_RUN, "hold_adv");
    end
    idle_cyc(E_WAIT, "hold_release");
    // Halt from step-advance, then reset with the drain counter at 1
    cyc(0, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, E_WAIT, "step_to_halt");
    cyc(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, E_DRN, "step_halt");
    idle_cyc(E_DRN, "drain_cnt2");
    cyc(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, E_IDLE, "reset_in_drain");
    idle_cyc(E_IDLE, "no_halt1");
    idle_cyc(E_IDLE, "no_halt2");
    idle_cyc(E_IDLE, "no_halt3");

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() > 0) begin
      bad++;
      $display("FAIL drain_queue: got %0d pending want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
